smg_scan_ctrl: RTL
==================

# smg_scan_ctrl

Avalon-MM slave that drives the board's 6-digit common-anode seven-segment display by time-multiplexing one digit at a time. It sits in the Nios II subsystem next to the interval timer. It can advance digits from its own prescaler or from the timer's periodic interrupt pulse, fed into `tick_in`. It raises a frame-complete interrupt after every full 6-digit scan.

## Interface
- `CLK_DIV`, default 50000: clk cycles per digit in internal-tick mode (1 ms at 50 MHz); must be ≥ 2.
- `BLANK_CYCLES`, default 500: all-digits-off cycles between digits (anti-ghosting); must be ≥ 1.
- `clk` input, 1 bit: system clock.
- `reset_n` input, 1 bit: reset, asynchronous, active-low.
- `chipselect` input, 1 bit: slave select.
- `address` input, 3 bits: register index.
- `write_n` input, 1 bit: active-low write strobe.
- `writedata` input, 16 bits: write data.
- `tick_in` input, 1 bit: external advance request, synchronous to clk; the rising edge is used.
- `readdata` output, 16 bits: registered read data.
- `seg` output, 8 bits: segments, active-low; [6:0]=g..a, [7]=dp.
- `sel` output, 6 bits: digit enables, active-low; bit n is digit n.
- `irq` output, 1 bit: frame_done & irq_en.

## Operation
- Register map; unused read bits return 0; writes to addresses 6–7 are ignored.
  - 0 STATUS: [0] frame_done, [1] running (state ≠ IDLE). Any write clears frame_done.
  - 1 CONTROL: [0] enable, [1] irq_en, [2] ext_tick. Writes take `writedata[2:0]`.
  - 2 DIG_L: four hex nibbles. Digit 0 is [3:0], digit 3 is [15:12].
  - 3 DIG_H: [3:0] digit 4, [7:4] digit 5.
  - 4 DP: [5:0] per-digit decimal point on.
  - 5 BLANK: [5:0] per-digit blank. A blanked digit keeps its `sel` slot but `seg` is 8'hFF.
- States:
  - IDLE → BLANK when enable=1. Entry sets digit index to 0.
  - BLANK → SHOW after BLANK_CYCLES cycles.
  - SHOW → BLANK on an advance event; digit index increments and wraps from 5 to 0.
  - Any state → IDLE on the cycle after enable is written 0.
- Advance event, internal mode (ext_tick=0): the prescaler resets on SHOW entry and counts only in SHOW. The event fires when the count reaches CLK_DIV-1, so SHOW lasts exactly CLK_DIV cycles.
- Advance event, external mode (ext_tick=1): `tick_in` is 0 last cycle and 1 this cycle, while in SHOW. Edges seen in BLANK/IDLE are discarded. The edge detector is always sampling.
- Changing ext_tick mid-SHOW applies from the next cycle; the prescaler is not reset.
- The index wrap 5→0 sets frame_done.
  - A STATUS write in the same cycle takes priority: frame_done ends 0.
- Hex decode (seg[6:0], active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - seg[7] = ~DP[idx].
- Outputs in each state:
  - IDLE and BLANK: `sel`=6'h3F, `seg`=8'hFF.
  - SHOW: `sel` = ~(1<<idx). `seg` is recomputed every cycle from the current registers, so register writes appear mid-digit.

## Timing
- Reset: seg=8'hFF, sel=6'h3F, irq=0, readdata=0, all registers 0, state IDLE, idx 0, prescaler 0, edge-detect register 0.
- `readdata` is registered and valid the cycle after address is presented with chipselect. No wait states. Reads have no side effects.
- Register writes take effect at the clock edge where chipselect & ~write_n.
- `seg` and `sel` are registered and change on the same edge as the state transition.
  - Example: enable written at edge E → BLANK from E+1 → first SHOW cycle at E+1+BLANK_CYCLES.
- `irq` is combinational from registered frame_done and irq_en. It asserts the cycle after the wrap edge.
- One scan period, internal mode: 6×(CLK_DIV+BLANK_CYCLES) cycles.
- Reset asserted mid-scan: outputs go to reset values immediately (asynchronously).

## Test plan
(Bench uses CLK_DIV=8, BLANK_CYCLES=2.)
- Reset/idle: hold reset_n=0, then release with no writes → seg=FF, sel=3F, irq=0 indefinitely; STATUS reads 0.
- Scan: DIG_L=0x3210, DIG_H=0x54, CONTROL=1 → after 2 blank cycles:
  - sel=3E and seg=C0 for 8 cycles, then 2 cycles of sel=3F.
  - Then sel=3D and seg=F9, continuing through digit 5 (sel=1F, seg=92).
  - Period is 60 cycles.
- Frame irq: CONTROL=3 → irq rises one cycle after the digit-5 SHOW ends. A STATUS write drops it the next cycle. A STATUS write on the wrap edge leaves irq=0.
- DP/blank: DP=0x01, BLANK=0x02 → digit 0 seg=40; digit 1 sel=3D with seg=FF.
- External tick: CONTROL=5, pulse tick_in every 20 cycles:
  - Each digit stays in SHOW until the tick edge.
  - A tick arriving during BLANK does not advance.
  - Holding tick_in=1 across SHOW entry does not advance.
- Disable and reset mid-scan:
  - Write CONTROL=0 during digit 3 → next cycle sel=3F, STATUS[1]=0. Re-enable restarts at digit 0.
  - Pulse reset_n during SHOW → outputs to reset values immediately and the registers clear.

Source files
------------

// File: rtl/smg_scan_ctrl.sv
// Avalon-MM seven-segment scan controller: multiplexes six common-anode digits one at a time,
// with blanking gaps between digits and a frame-complete interrupt after each full scan.
module smg_scan_ctrl #(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        chipselect,
   input  logic [2:0]  address,
   input  logic        write_n,
   input  logic [15:0] writedata,
   input  logic        tick_in,
   output logic [15:0] readdata,
   output logic [7:0]  seg,
   output logic [5:0]  sel,
   output logic        irq
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          tick_q;
   logic          frame_done_q, frame_done_d;
   logic          enable_q, enable_d;
   logic          irq_en_q, irq_en_d;
   logic          ext_tick_q, ext_tick_d;
   logic [15:0]   dig_l_q, dig_l_d;
   logic [7:0]    dig_h_q, dig_h_d;
   logic [5:0]    dp_q, dp_d;
   logic [5:0]    blank_q, blank_d;
   logic [15:0]   readdata_d;
   logic [7:0]    seg_d;
   logic [5:0]    sel_d;
   logic          wr, rd, tick_edge, advance, wrap;
   logic [3:0]    nibble;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      wr           = chipselect & ~write_n;
      rd           = chipselect & write_n;
      tick_edge    = tick_in & ~tick_q;
      state_d      = state_q;
      idx_d        = idx_q;
      presc_d      = presc_q;
      bcnt_d       = bcnt_q;
      frame_done_d = frame_done_q;
      enable_d     = enable_q;
      irq_en_d     = irq_en_q;
      ext_tick_d   = ext_tick_q;
      dig_l_d      = dig_l_q;
      dig_h_d      = dig_h_q;
      dp_d         = dp_q;
      blank_d      = blank_q;
      readdata_d   = readdata;
      advance      = 1'b0;
      wrap         = 1'b0;
      nibble       = 4'h0;
      seg_d        = 8'hFF;
      sel_d        = 6'h3F;

      if (wr) begin
         case (address)
            3'd1: begin
               enable_d   = writedata[0];
               irq_en_d   = writedata[1];
               ext_tick_d = writedata[2];
            end
            3'd2: dig_l_d = writedata;
            3'd3: dig_h_d = writedata[7:0];
            3'd4: dp_d    = writedata[5:0];
            3'd5: blank_d = writedata[5:0];
            default: ;
         endcase
      end

      if (rd) begin
         case (address)
            3'd0: readdata_d = {14'd0, state_q != ST_IDLE, frame_done_q};
            3'd1: readdata_d = {13'd0, ext_tick_q, irq_en_q, enable_q};
            3'd2: readdata_d = dig_l_q;
            3'd3: readdata_d = {8'd0, dig_h_q};
            3'd4: readdata_d = {10'd0, dp_q};
            3'd5: readdata_d = {10'd0, blank_q};
            default: readdata_d = 16'd0;
         endcase
      end

      // A cleared enable overrides whatever the scan would have done this cycle.
      if (!enable_q) begin
         state_d = ST_IDLE;
         idx_d   = 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_BLANK;
               idx_d   = 3'd0;
               bcnt_d  = '0;
            end
            ST_BLANK: begin
               if (bcnt_q == BLANK_LAST) begin
                  state_d = ST_SHOW;
                  presc_d = '0;
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
            ST_SHOW: begin
               presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
               advance = ext_tick_q ? tick_edge : (presc_q == PRESC_LAST);
               if (advance) begin
                  state_d = ST_BLANK;
                  bcnt_d  = '0;
                  if (idx_q == 3'd5) begin
                     idx_d = 3'd0;
                     wrap  = 1'b1;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (wr && address == 3'd0) frame_done_d = 1'b0;
      else if (wrap)             frame_done_d = 1'b1;

      case (idx_d)
         3'd0: nibble = dig_l_q[3:0];
         3'd1: nibble = dig_l_q[7:4];
         3'd2: nibble = dig_l_q[11:8];
         3'd3: nibble = dig_l_q[15:12];
         3'd4: nibble = dig_h_q[3:0];
         3'd5: nibble = dig_h_q[7:4];
         default: nibble = 4'h0;
      endcase

      // Segment data follows the live registers so writes show up mid-digit.
      if (state_d == ST_SHOW) begin
         sel_d = ~(6'b000001 << idx_d);
         if (!blank_q[idx_d]) seg_d = {~dp_q[idx_d], hex7(nibble)};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= 3'd0;
         presc_q      <= '0;
         bcnt_q       <= '0;
         tick_q       <= 1'b0;
         frame_done_q <= 1'b0;
         enable_q     <= 1'b0;
         irq_en_q     <= 1'b0;
         ext_tick_q   <= 1'b0;
         dig_l_q      <= 16'd0;
         dig_h_q      <= 8'd0;
         dp_q         <= 6'd0;
         blank_q      <= 6'd0;
         readdata     <= 16'd0;
         seg          <= 8'hFF;
         sel          <= 6'h3F;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         presc_q      <= presc_d;
         bcnt_q       <= bcnt_d;
         tick_q       <= tick_in;
         frame_done_q <= frame_done_d;
         enable_q     <= enable_d;
         irq_en_q     <= irq_en_d;
         ext_tick_q   <= ext_tick_d;
         dig_l_q      <= dig_l_d;
         dig_h_q      <= dig_h_d;
         dp_q         <= dp_d;
         blank_q      <= blank_d;
         readdata     <= readdata_d;
         seg          <= seg_d;
         sel          <= sel_d;
      end
   end

   assign irq = frame_done_q & irq_en_q;

endmodule
